// File: rtl/regfile_sb_pkg.sv
// Shared types and sizing for the regfile_sb register file and scoreboard.
// Optional build macro used by this slice: REGFILE_BYPASS_EN (write-to-read forwarding).
package regfile_sb_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned IDX_W = $clog2(NREG);
  localparam int unsigned CNT_W = 2;

  typedef logic [IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]  xlen_t;
  typedef logic [CNT_W-1:0] sb_cnt_t;

  localparam reg_idx_t X0      = IDX_W'(0);
  localparam sb_cnt_t  CNT_MAX = '1;

endpackage

// File: rtl/regfile_sb_if.sv
// Pipeline-to-register-file bus: writeback, decode read ports, issue and hazard status.
interface regfile_sb_if;
  import regfile_sb_pkg::*;

  reg_idx_t write_addr_i;
  xlen_t    write_data_i;
  logic     regwrite_i;
  reg_idx_t rs1_addr;
  reg_idx_t rs2_addr;
  logic     rs1_used;
  logic     rs2_used;
  xlen_t    rs1_data;
  xlen_t    rs2_data;
  logic     issue_valid;
  reg_idx_t issue_rd;
  logic     issue_regwrite;
  logic     stall_o;
  logic     sb_err_o;

  modport master (
    output write_addr_i, write_data_i, regwrite_i,
    output rs1_addr, rs2_addr, rs1_used, rs2_used,
    output issue_valid, issue_rd, issue_regwrite,
    input  rs1_data, rs2_data, stall_o, sb_err_o
  );

  modport slave (
    input  write_addr_i, write_data_i, regwrite_i,
    input  rs1_addr, rs2_addr, rs1_used, rs2_used,
    input  issue_valid, issue_rd, issue_regwrite,
    output rs1_data, rs2_data, stall_o, sb_err_o
  );

endinterface

// File: rtl/regfile_sb_cnt.sv
// One register's pending-write counter: saturating up/down with an over/underflow pulse.
module regfile_sb_cnt
  import regfile_sb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    inc,
  input  logic    dec,
  output sb_cnt_t cnt,
  output logic    err_c
);

  // Issue and retire on the same edge cancel; otherwise step while in range.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && !dec && cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // A blocked step is a scoreboard protocol error.
  assign err_c = (inc && !dec && cnt == CNT_MAX) || (dec && !inc && cnt == '0);

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with two async read ports and a per-register pending-write scoreboard.
// Optional build macro: REGFILE_BYPASS_EN forwards same-cycle writeback data and retire to reads.
module regfile_sb
  import regfile_sb_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);

  xlen_t           regs [NREG];
  sb_cnt_t         cnt  [NREG];
  logic [NREG-1:0] err_vec;
  logic            issue_ev;
  logic            retire_ev;
  logic            haz1;
  logic            haz2;
  logic            sb_err_q;

  assign issue_ev  = bus.issue_valid && bus.issue_regwrite && (bus.issue_rd != X0);
  assign retire_ev = bus.regwrite_i && (bus.write_addr_i != X0);

  // Register array; writes to x0 are dropped so it always reads back zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else if (retire_ev) begin
      regs[bus.write_addr_i] <= bus.write_data_i;
    end
  end

  // x0 has no pending writes by construction.
  assign cnt[0]     = '0;
  assign err_vec[0] = 1'b0;

  for (genvar r = 1; r < int'(NREG); r++) begin : g_cnt
    regfile_sb_cnt u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (issue_ev  && (bus.issue_rd     == IDX_W'(r))),
      .dec   (retire_ev && (bus.write_addr_i == IDX_W'(r))),
      .cnt   (cnt[r]),
      .err_c (err_vec[r])
    );
  end

  // Sticky scoreboard error until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_err_q <= 1'b0;
    end else if (|err_vec) begin
      sb_err_q <= 1'b1;
    end
  end

  assign bus.sb_err_o = sb_err_q;

  // Read ports and hazard detection.
  always_comb begin
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    if (bus.rs1_addr != X0) bus.rs1_data = regs[bus.rs1_addr];
    if (bus.rs2_addr != X0) bus.rs2_data = regs[bus.rs2_addr];
    haz1 = bus.rs1_used && (bus.rs1_addr != X0) && (cnt[bus.rs1_addr] != '0);
    haz2 = bus.rs2_used && (bus.rs2_addr != X0) && (cnt[bus.rs2_addr] != '0);
`ifdef REGFILE_BYPASS_EN
    if (retire_ev && bus.write_addr_i == bus.rs1_addr) begin
      bus.rs1_data = bus.write_data_i;
      if (cnt[bus.rs1_addr] == CNT_W'(1)) haz1 = 1'b0;
    end
    if (retire_ev && bus.write_addr_i == bus.rs2_addr) begin
      bus.rs2_data = bus.write_data_i;
      if (cnt[bus.rs2_addr] == CNT_W'(1)) haz2 = 1'b0;
    end
`endif
    bus.stall_o = haz1 || haz2;
  end

  // Decode must hold a stalled instruction rather than issue it.
  a_no_issue_on_stall: assert property (@(posedge clk) disable iff (rst)
    !(bus.stall_o && bus.issue_valid));

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: directed stimulus pushes expectations, a negedge monitor checks them.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        st;
    logic        er;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  regfile_sb_if bus();

  regfile_sb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input string field, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so each expectation is checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.name, "rs1_data", bus.rs1_data, e.d1);
      cmp(e.name, "rs2_data", bus.rs2_data, e.d2);
      cmp(e.name, "stall_o", 32'(bus.stall_o), 32'(e.st));
      cmp(e.name, "sb_err_o", 32'(bus.sb_err_o), 32'(e.er));
    end
  end

  task automatic drv(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic iv, input logic [4:0] ird,
                     input logic [4:0] r1, input logic u1,
                     input logic [4:0] r2, input logic u2);
    bus.regwrite_i     = we;
    bus.write_addr_i   = wa;
    bus.write_data_i   = wd;
    bus.issue_valid    = iv;
    bus.issue_regwrite = iv;
    bus.issue_rd       = ird;
    bus.rs1_addr       = r1;
    bus.rs1_used       = u1;
    bus.rs2_addr       = r2;
    bus.rs2_used       = u2;
  endtask

  task automatic expect_out(input string name, input logic [31:0] d1, input logic [31:0] d2,
                            input logic st, input logic er);
    exp_t e;
    e.name = name;
    e.d1   = d1;
    e.d2   = d2;
    e.st   = st;
    e.er   = er;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wait_cyc;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Every address on both ports reads zero after reset.
    for (int a = 0; a < 32; a++) begin
      drv(0, 0, 0, 0, 0, 5'(a), 1, 5'(31 - a), 1);
      expect_out("rst_read", 0, 0, 0, 0);
      tick();
    end

    // Write x5 (issued first so the retire is legal); x0 writes are ignored.
    drv(0, 0, 0, 1, 5, 0, 0, 0, 0);           expect_out("iss5", 0, 0, 0, 0); tick();
    drv(1, 5, 32'hDEADBEEF, 0, 0, 5, 1, 0, 0);
    expect_out("wr5_same", BYP ? 32'hDEADBEEF : 32'h0, 0, !BYP, 0); tick();
    drv(1, 0, 32'h12345678, 0, 0, 5, 1, 0, 1); expect_out("wr5_next", 32'hDEADBEEF, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 5, 1, 0, 1);            expect_out("x0_read", 32'hDEADBEEF, 0, 0, 0); tick();

    // Single outstanding write to x7.
    drv(0, 0, 0, 1, 7, 0, 0, 0, 0);            expect_out("iss7", 0, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 7, 1, 0, 0);            expect_out("haz7", 0, 0, 1, 0); tick();
    drv(1, 7, 32'h55, 0, 0, 7, 1, 0, 0);
    expect_out("ret7", BYP ? 32'h55 : 32'h0, 0, !BYP, 0); tick();
    drv(0, 0, 0, 0, 0, 7, 1, 0, 0);            expect_out("post7", 32'h55, 0, 0, 0); tick();

    // Two outstanding writes to x3, then a same-cycle issue+retire at count 1.
    drv(0, 0, 0, 1, 3, 0, 0, 0, 0);            expect_out("iss3a", 0, 0, 0, 0); tick();
    drv(0, 0, 0, 1, 3, 0, 0, 0, 0);            expect_out("iss3b", 0, 0, 0, 0); tick();
    drv(1, 3, 32'h33, 0, 0, 3, 1, 0, 0);
    expect_out("ret3a", BYP ? 32'h33 : 32'h0, 0, 1, 0); tick();
    drv(0, 0, 0, 0, 0, 3, 1, 0, 0);            expect_out("hold3", 32'h33, 0, 1, 0); tick();
    drv(1, 3, 32'h44, 1, 3, 3, 0, 0, 0);
    expect_out("iss_ret3", BYP ? 32'h44 : 32'h33, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 3, 1, 0, 0);            expect_out("cnt3_one", 32'h44, 0, 1, 0); tick();
    drv(1, 3, 32'h45, 0, 0, 3, 1, 0, 0);
    expect_out("ret3b", BYP ? 32'h45 : 32'h44, 0, !BYP, 0); tick();
    drv(0, 0, 0, 0, 0, 3, 1, 3, 1);            expect_out("clr3", 32'h45, 32'h45, 0, 0); tick();

    // Retire to x12 with no pending write: error, but the write still lands.
    drv(1, 12, 32'hC12, 0, 0, 0, 0, 12, 1);
    expect_out("uf12", 0, BYP ? 32'hC12 : 32'h0, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 12, 1);           expect_out("uf12_err", 0, 32'hC12, 0, 1); tick();

    // Reset overrides a simultaneous write and issue with cnt[4]=2.
    drv(0, 0, 0, 1, 4, 0, 0, 0, 0);            expect_out("iss4a", 0, 0, 0, 1); tick();
    drv(0, 0, 0, 1, 4, 0, 0, 0, 0);            expect_out("iss4b", 0, 0, 0, 1); tick();
    drv(1, 4, 32'hAAAA, 1, 4, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 4, 1, 5, 1);            expect_out("post_rst", 0, 0, 0, 0); tick();

    // Four issues to x9 saturate at 3 and set the sticky error.
    for (int k = 0; k < 4; k++) begin
      drv(0, 0, 0, 1, 9, 0, 0, 0, 0);          expect_out("iss9", 0, 0, 0, 0); tick();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 9, 1);            expect_out("sat9", 0, 0, 1, 1); tick();
    drv(1, 9, 32'h1, 0, 0, 0, 0, 9, 1);
    expect_out("r9a", 0, BYP ? 32'h1 : 32'h0, 1, 1); tick();
    drv(1, 9, 32'h2, 0, 0, 0, 0, 9, 1);
    expect_out("r9b", 0, BYP ? 32'h2 : 32'h1, 1, 1); tick();
    drv(1, 9, 32'h3, 0, 0, 0, 0, 9, 1);
    expect_out("r9c", 0, BYP ? 32'h3 : 32'h2, !BYP, 1); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 9, 1);            expect_out("r9_done", 0, 32'h3, 0, 1); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 9, 1);            expect_out("err_sticky", 0, 32'h3, 0, 1); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      tick();
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Integer register file that consumes the writeback stage's output: write address, write data and write enable.
- Serves two combinational read ports to the decode stage.
- Holds a per-register pending-write scoreboard.
  - Decode marks a destination busy at issue.
  - Writeback retires it.
  - Busy source operands drive a stall back to the pipeline.
- x0 is hardwired to zero.

Parameters:
- NREG, 32, number of architectural registers; index width is log2(NREG) = 5.
- XLEN, 32, data width.
- CNT_W, 2, width of each per-register pending-write counter; maximum in-flight writes to one register is 2^CNT_W-1 = 3.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- write_addr_i  in  5  writeback destination register.
- write_data_i  in  32  writeback data.
- regwrite_i  in  1  writeback write enable.
- rs1_addr  in  5  read port 1 address.
- rs2_addr  in  5  read port 2 address.
- rs1_used  in  1  decode actually consumes rs1 this cycle.
- rs2_used  in  1  decode actually consumes rs2 this cycle.
- rs1_data  out  32  read port 1 data, combinational.
- rs2_data  out  32  read port 2 data, combinational.
- issue_valid  in  1  an instruction leaves decode this cycle.
- issue_rd  in  5  its destination register.
- issue_regwrite  in  1  it writes a register.
- stall_o  out  1  read-after-write hazard; decode must hold.
- sb_err_o  out  1  sticky scoreboard overflow/underflow flag.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All registers cleared to 0.
  - All counters cleared to 0.
  - sb_err_o cleared.
  - Reset overrides write, issue and retire in the same cycle.
  - After reset: rs1_data = rs2_data = 0 and stall_o = 0.
- Write:
  - When regwrite_i=1 and write_addr_i!=0, reg[write_addr_i] <= write_data_i at the edge.
  - A write to x0 is ignored and x0 always reads 0.
- Read:
  - rsN_data = 0 if rsN_addr==0, else reg[rsN_addr].
  - Read is asynchronous (zero latency).
  - A write becomes visible one cycle after its edge unless the optional bypass is built.
- Scoreboard:
  - Issue event: issue_valid & issue_regwrite & issue_rd!=0.
  - Retire event: regwrite_i & write_addr_i!=0.
  - Per register r at the clock edge:
    - Issue only: cnt[r] += 1.
    - Retire only: cnt[r] -= 1.
    - Issue and retire on the same r: cnt[r] unchanged.
    - Issue and retire on different registers: each updated independently.
  - Saturation: an issue when cnt[r]==3 (without a same-cycle retire of r) leaves cnt at 3 and sets sb_err_o.
  - Underflow: a retire when cnt[r]==0 leaves cnt at 0 and sets sb_err_o. The register write still happens.
  - cnt[0] is constant 0.
- Stall:
  - hazN = rsN_used & rsN_addr!=0 & cnt[rsN_addr]!=0, with the bypass exception given under Optional Feature.
  - stall_o = haz1 | haz2, purely combinational.
  - A stalled instruction must not assert issue_valid; this is the decode stage's obligation and is checked by assertion.
- sb_err_o is sticky until rst.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding: if regwrite_i & write_addr_i!=0 & write_addr_i==rsN_addr, then rsN_data = write_data_i in the same cycle.
  - hazN is suppressed when the same-cycle retire targets rsN_addr and cnt[rsN_addr]==1.
- Undefined:
  - No forwarding; the new value is visible the cycle after the write.
  - Stall holds through the retire cycle.

Decomposition:
- Shared package (defines header): XLEN, NREG, register index width, CNT_W, and the constant for x0 (5'd0).
- One natural sub-module: regfile_sb_cnt, a single per-register saturating up/down counter with error output. It is instantiated NREG-1 times via generate; x0 is tied off.

Test Plan:
- Reset, then read every address on both ports -> all 0; stall_o=0, sb_err_o=0.
- Write x5=0xDEADBEEF; next cycle rs1_addr=5 -> 0xDEADBEEF. Write x0=0x12345678; rs2_addr=0 -> 0.
- Issue rd=7; next cycle rs1_addr=7, rs1_used=1 -> stall_o=1. Retire x7=0x55 -> bypass built: stall_o=0 and rs1_data=0x55 in the retire cycle. No bypass: stall_o=0 one cycle later.
- Issue rd=3 twice, retire once -> stall_o stays 1; second retire -> stall_o=0. Same-cycle issue and retire on x3 with cnt=1 -> cnt stays 1.
- Four issues to rd=9 without retire -> cnt saturates at 3, sb_err_o=1 and stays 1. Retire to x12 with cnt=0 -> sb_err_o=1, and x12 is written.
- Assert rst mid-sequence with cnt[4]=2 and a simultaneous write -> all registers and counters 0, no write lands, stall_o=0.
